// File: rtl/ks10_ramfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ks10_ramfile_pkg
// Description : Shared constants and state encodings for the RAMFILE
//               controller and its console handshake sub-module.
// Revision    : 1.0 - initial release
// ============================================================================
package ks10_ramfile_pkg;

    localparam int RAMFILE_ADDR_WIDTH = 10;
    localparam int RAMFILE_DATA_WIDTH = 36;
    localparam int RAMFILE_SP_ADDR    = 15;
    localparam logic [RAMFILE_DATA_WIDTH-1:0] RAMFILE_SP_INIT = 36'o777577_030303;

    // Power-up sequencer: INIT clears the RAM, RUN hands it to the requesters.
    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } init_state_t;

    // Console handshake: one RAM access per req/ack cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } con_state_t;

endpackage : ks10_ramfile_pkg
`default_nettype wire

// File: rtl/ramfile_ctl_con.sv
`default_nettype none
// ============================================================================
// Module      : ramfile_ctl_con
// Description : Console req/ack FSM. Latches the request, waits for a cycle
//               the CPU leaves idle, captures the read data and acks until
//               the request drops.
// Revision    : 1.0 - initial release
// ============================================================================
module ramfile_ctl_con
    import ks10_ramfile_pkg::*;
#(
    parameter int ADDR_WIDTH = RAMFILE_ADDR_WIDTH,
    parameter int DATA_WIDTH = RAMFILE_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  cpu_clken,
    input  logic                  con_req,
    input  logic                  con_wr,
    input  logic [ADDR_WIDTH-1:0] con_addr,
    input  logic [DATA_WIDTH-1:0] con_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  con_ack,
    output logic [DATA_WIDTH-1:0] con_dout,
    output logic                  issue,
    output logic                  lat_wr,
    output logic [ADDR_WIDTH-1:0] lat_addr,
    output logic [DATA_WIDTH-1:0] lat_din
);

    con_state_t            r_state;
    con_state_t            w_next;
    logic                  w_accept;
    logic                  r_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;
    logic [DATA_WIDTH-1:0] r_dout;

    // Requests are only taken once the RAM has been initialised.
    assign w_accept = (r_state == IDLE) && con_req && run;

    // Console FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; DONE holds until con_req drops so a held request
    // cannot trigger a second access.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_next = PEND;
            PEND:    if (!cpu_clken) w_next = DATA;
            DATA:                    w_next = DONE;
            DONE:    if (!con_req)   w_next = IDLE;
            default:                 w_next = IDLE;
        endcase
    end

    // Request latches, captured on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr   <= 1'b0;
            r_addr <= '0;
            r_din  <= '0;
        end else if (w_accept) begin
            r_wr   <= con_wr;
            r_addr <= con_addr;
            r_din  <= con_din;
        end
    end

    // Read data is valid in DATA; capturing at its end keeps a CPU access in
    // the same cycle from disturbing the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout <= '0;
        end else if (r_state == DATA) begin
            r_dout <= ram_dout;
        end
    end

    assign con_ack  = (r_state == DONE);
    assign con_dout = r_dout;
    assign issue    = (r_state == PEND) && !cpu_clken;
    assign lat_wr   = r_wr;
    assign lat_addr = r_addr;
    assign lat_din  = r_din;

endmodule : ramfile_ctl_con
`default_nettype wire

// File: rtl/ramfile_ctl.sv
`default_nettype none
// ============================================================================
// Module      : ramfile_ctl
// Description : RAMFILE sequencer and arbiter. Clears the RAM after reset
//               (stack pointer word preset), then gives the CPU absolute
//               priority and the console the idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module ramfile_ctl
    import ks10_ramfile_pkg::*;
#(
    parameter int                    ADDR_WIDTH = RAMFILE_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = RAMFILE_DATA_WIDTH,
    parameter int                    SP_ADDR    = RAMFILE_SP_ADDR,
    parameter logic [DATA_WIDTH-1:0] SP_INIT    = RAMFILE_SP_INIT
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    input  logic                  cpu_clken,
    input  logic                  cpu_wr,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_din,
    input  logic                  con_req,
    input  logic                  con_wr,
    input  logic [ADDR_WIDTH-1:0] con_addr,
    input  logic [DATA_WIDTH-1:0] con_din,
    output logic                  con_ack,
    output logic [DATA_WIDTH-1:0] con_dout,
    output logic                  ram_clken,
    output logic                  ram_wr,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam logic [ADDR_WIDTH-1:0] c_last    = '1;
    localparam logic [ADDR_WIDTH-1:0] c_sp_addr = ADDR_WIDTH'(SP_ADDR);

    init_state_t           r_init_state;
    init_state_t           w_init_next;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  w_run;
    logic                  w_issue;
    logic                  w_lat_wr;
    logic [ADDR_WIDTH-1:0] w_lat_addr;
    logic [DATA_WIDTH-1:0] w_lat_din;

    assign w_run = (r_init_state == RUN);
    assign busy  = (r_init_state == INIT);

    // Init FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_init_state <= INIT;
        end else begin
            r_init_state <= w_init_next;
        end
    end

    // Leave INIT right after the write to the last word.
    always_comb begin
        w_init_next = r_init_state;
        if ((r_init_state == INIT) && (r_cnt == c_last)) begin
            w_init_next = RUN;
        end
    end

    // Init address counter; stops at the last word instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((r_init_state == INIT) && (r_cnt != c_last)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    ramfile_ctl_con #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_con (
        .clk       (clk),
        .rst       (rst),
        .run       (w_run),
        .cpu_clken (cpu_clken),
        .con_req   (con_req),
        .con_wr    (con_wr),
        .con_addr  (con_addr),
        .con_din   (con_din),
        .ram_dout  (ram_dout),
        .con_ack   (con_ack),
        .con_dout  (con_dout),
        .issue     (w_issue),
        .lat_wr    (w_lat_wr),
        .lat_addr  (w_lat_addr),
        .lat_din   (w_lat_din)
    );

    // RAM port mux: init writes, then CPU first, console on idle CPU cycles.
    always_comb begin
        ram_clken = 1'b0;
        ram_wr    = 1'b0;
        ram_addr  = '0;
        ram_din   = '0;
        if (!w_run) begin
            ram_clken = 1'b1;
            ram_wr    = 1'b1;
            ram_addr  = r_cnt;
            ram_din   = (r_cnt == c_sp_addr) ? SP_INIT : '0;
        end else if (cpu_clken) begin
            ram_clken = 1'b1;
            ram_wr    = cpu_wr;
            ram_addr  = cpu_addr;
            ram_din   = cpu_din;
        end else if (w_issue) begin
            ram_clken = 1'b1;
            ram_wr    = w_lat_wr;
            ram_addr  = w_lat_addr;
            ram_din   = w_lat_din;
        end
    end

endmodule : ramfile_ctl
`default_nettype wire

// File: tb/tb_ramfile_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ramfile_ctl
// Description : Self-checking bench for ramfile_ctl with a behavioural
//               RAMFILE (registered read address, single clock enable).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ramfile_ctl;
    import ks10_ramfile_pkg::*;

    localparam logic [35:0] c_poison = 36'o525252_525252;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        busy;
    logic        cpu_clken = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [9:0]  cpu_addr = '0;
    logic [35:0] cpu_din = '0;
    logic        con_req = 1'b0;
    logic        con_wr = 1'b0;
    logic [9:0]  con_addr = '0;
    logic [35:0] con_din = '0;
    logic        con_ack;
    logic [35:0] con_dout;
    logic        ram_clken;
    logic        ram_wr;
    logic [9:0]  ram_addr;
    logic [35:0] ram_din;
    logic [35:0] ram_dout;

    int total = 0;
    int bad   = 0;

    logic [35:0] exp_q[$];
    logic [35:0] shadow [0:1023];
    logic [35:0] got_exp;

    logic [35:0] mem [0:1023];
    logic [9:0]  raddr;
    int          acc_cnt = 0;
    logic        armed = 1'b0;
    logic        poison_hit = 1'b0;

    always #5 clk = ~clk;

    ramfile_ctl dut (
        .clk       (clk),
        .rst       (rst),
        .busy      (busy),
        .cpu_clken (cpu_clken),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .con_req   (con_req),
        .con_wr    (con_wr),
        .con_addr  (con_addr),
        .con_din   (con_din),
        .con_ack   (con_ack),
        .con_dout  (con_dout),
        .ram_clken (ram_clken),
        .ram_wr    (ram_wr),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // RAMFILE model: synchronous write, registered read address.
    always @(posedge clk) begin
        if (ram_clken) begin
            if (ram_wr) mem[ram_addr] <= ram_din;
            raddr <= ram_addr;
        end
    end
    assign ram_dout = mem[raddr];

    // Access counter and detector for a write that must never happen.
    always @(posedge clk) begin
        if (ram_clken) acc_cnt <= acc_cnt + 1;
        if (armed && ram_clken && ram_wr && (ram_din == c_poison)) poison_hit <= 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shadow_init();
        for (int i = 0; i < 1024; i++) shadow[i] = '0;
        shadow[15] = RAMFILE_SP_INIT;
    endtask

    task automatic drive_req(input logic wr, input logic [9:0] a, input logic [35:0] d);
        con_req  = 1'b1;
        con_wr   = wr;
        con_addr = a;
        con_din  = d;
        if (wr) shadow[a] = d;
        exp_q.push_back(shadow[a]);
    endtask

    task automatic wait_ack(input int max, output int n);
        n = 0;
        while (!con_ack && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic pop_exp(output logic [35:0] e);
        if (exp_q.size() == 0) e = 36'hx_xxxx_xxxx;
        else e = exp_q.pop_front();
    endtask

    task automatic count_init(input string tag);
        int n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        total++;
        if (n !== 1024) begin
            bad++;
            $display("FAIL %s_busy_len: got %0d cycles, want 1024", tag, n);
        end
    endtask

    task automatic test_reset();
        int n = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b1 || con_ack !== 1'b0 || con_dout !== 36'd0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b ack=%b dout=%o, want 1 0 0", busy, con_ack, con_dout);
        end
        tick(); tick();
        total++;
        if (ram_clken !== 1'b1 || ram_wr !== 1'b1 || ram_addr !== 10'd0 || ram_din !== 36'd0) begin
            bad++;
            $display("FAIL reset_ram_port: clken=%b wr=%b addr=%0d din=%o, want 1 1 0 0",
                     ram_clken, ram_wr, ram_addr, ram_din);
        end
        rst = 1'b0;
        while (busy && n < 2000) begin
            if (ram_addr == 10'd15) begin
                total++;
                if (ram_din !== RAMFILE_SP_INIT) begin
                    bad++;
                    $display("FAIL init_sp_word: got %o, want %o", ram_din, RAMFILE_SP_INIT);
                end
            end
            tick();
            n++;
        end
        total++;
        if (n !== 1024) begin
            bad++;
            $display("FAIL init_busy_len: got %0d cycles, want 1024", n);
        end
        total++;
        if (ram_clken !== 1'b0) begin
            bad++;
            $display("FAIL run_idle_clken: got %b, want 0", ram_clken);
        end
        shadow_init();
    endtask

    task automatic test_init_contents();
        logic [9:0] addrs [3];
        int n;
        logic [35:0] e;
        addrs[0] = 10'd0; addrs[1] = 10'd15; addrs[2] = 10'd1023;
        foreach (addrs[k]) begin
            drive_req(1'b0, addrs[k], '0);
            wait_ack(10, n);
            pop_exp(e);
            total++;
            if (n !== 3 || con_dout !== e) begin
                bad++;
                $display("FAIL init_read[%0d]: latency=%0d dout=%o, want 3 %o", addrs[k], n, con_dout, e);
            end
            con_req = 1'b0;
            tick();
        end
    endtask

    task automatic test_con_write();
        int n;
        logic [35:0] e;
        drive_req(1'b1, 10'o1234, 36'o123456_701234);
        wait_ack(10, n);
        pop_exp(e);
        total++;
        if (n !== 3 || con_dout !== e) begin
            bad++;
            $display("FAIL con_write: latency=%0d dout=%o, want 3 %o", n, con_dout, e);
        end
        con_req   = 1'b0;
        cpu_clken = 1'b1;
        cpu_wr    = 1'b0;
        cpu_addr  = 10'o1234;
        #1;
        total++;
        if (ram_clken !== 1'b1 || ram_wr !== 1'b0 || ram_addr !== 10'o1234) begin
            bad++;
            $display("FAIL cpu_mux_read: clken=%b wr=%b addr=%o, want 1 0 1234", ram_clken, ram_wr, ram_addr);
        end
        tick();
        cpu_clken = 1'b0;
        total++;
        if (ram_dout !== 36'o123456_701234) begin
            bad++;
            $display("FAIL cpu_readback: got %o, want 123456701234", ram_dout);
        end
    endtask

    task automatic test_cpu_priority();
        int n;
        logic [35:0] e;
        int errs = 0;
        cpu_clken = 1'b1;
        drive_req(1'b0, 10'd15, '0);
        for (int i = 0; i < 20; i++) begin
            cpu_addr = 10'($urandom_range(0, 1023));
            cpu_din  = {4'($urandom), 32'($urandom)};
            cpu_wr   = (cpu_addr != 10'd15) && ($urandom_range(0, 1) == 1);
            if (cpu_wr) shadow[cpu_addr] = cpu_din;
            #1;
            if (ram_clken !== 1'b1 || ram_wr !== cpu_wr || ram_addr !== cpu_addr ||
                ram_din !== cpu_din || con_ack !== 1'b0) errs++;
            tick();
        end
        cpu_clken = 1'b0;
        cpu_wr    = 1'b0;
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL cpu_priority_mux: %0d cycles wrong, want 0", errs);
        end
        // Two more cycles from here: three after the last cycle with cpu_clken high.
        wait_ack(10, n);
        pop_exp(e);
        total++;
        if (n !== 2 || con_dout !== e) begin
            bad++;
            $display("FAIL cpu_priority_ack: latency=%0d dout=%o, want 2 %o", n, con_dout, e);
        end
        con_req = 1'b0;
        tick();
    endtask

    task automatic test_held_req();
        int n;
        int a0;
        int errs = 0;
        logic [35:0] e;
        a0 = acc_cnt;
        drive_req(1'b0, 10'o1234, '0);
        wait_ack(10, n);
        pop_exp(e);
        total++;
        if (n !== 3 || con_dout !== e) begin
            bad++;
            $display("FAIL held_first: latency=%0d dout=%o, want 3 %o", n, con_dout, e);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (con_ack !== 1'b1) errs++;
        end
        total++;
        if (errs !== 0 || (acc_cnt - a0) !== 1) begin
            bad++;
            $display("FAIL held_single_access: ack_drops=%0d accesses=%0d, want 0 1", errs, acc_cnt - a0);
        end
        con_req = 1'b0;
        tick();
        total++;
        if (con_ack !== 1'b0) begin
            bad++;
            $display("FAIL held_ack_release: got %b, want 0", con_ack);
        end
        drive_req(1'b1, 10'o77, 36'o000111_222333);
        wait_ack(10, n);
        pop_exp(e);
        total++;
        if (n !== 3 || con_dout !== e) begin
            bad++;
            $display("FAIL held_second: latency=%0d dout=%o, want 3 %o", n, con_dout, e);
        end
        con_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_abort();
        int n = 0;
        logic [35:0] e;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        while (ram_addr != 10'd500 && n < 600) begin
            tick();
            n++;
        end
        rst = 1'b1;
        #1;
        total++;
        if (n !== 500 || busy !== 1'b1 || ram_addr !== 10'd0) begin
            bad++;
            $display("FAIL mid_init_reset: reached=%0d busy=%b addr=%0d, want 500 1 0", n, busy, ram_addr);
        end
        tick();
        rst = 1'b0;
        count_init("restart");
        shadow_init();
        cpu_clken = 1'b1;
        cpu_addr  = 10'd0;
        con_req   = 1'b1;
        con_wr    = 1'b1;
        con_addr  = 10'd5;
        con_din   = c_poison;
        tick(); tick();
        armed = 1'b1;
        rst   = 1'b1;
        #1;
        total++;
        if (con_ack !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL pend_reset: ack=%b busy=%b, want 0 1", con_ack, busy);
        end
        con_req   = 1'b0;
        cpu_clken = 1'b0;
        tick();
        rst = 1'b0;
        count_init("pend_restart");
        drive_req(1'b0, 10'd5, '0);
        wait_ack(10, n);
        pop_exp(e);
        total++;
        if (n !== 3 || con_dout !== e || poison_hit !== 1'b0) begin
            bad++;
            $display("FAIL dropped_write: latency=%0d dout=%o poison=%b, want 3 %o 0", n, con_dout, poison_hit, e);
        end
        armed   = 1'b0;
        con_req = 1'b0;
        tick();
    endtask

    task automatic test_init_req();
        int n = 0;
        int early = 0;
        logic [35:0] e;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        shadow_init();
        drive_req(1'b0, 10'd15, '0);
        while (busy && n < 2000) begin
            if (con_ack) early++;
            tick();
            n++;
        end
        total++;
        if (n !== 1024 || early !== 0) begin
            bad++;
            $display("FAIL init_req_hold: busy=%0d ack_during_init=%0d, want 1024 0", n, early);
        end
        wait_ack(10, n);
        pop_exp(e);
        total++;
        if (n !== 3 || con_dout !== e) begin
            bad++;
            $display("FAIL init_req_serve: latency=%0d dout=%o, want 3 %o", n, con_dout, e);
        end
        con_req = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        shadow_init();
        test_reset();
        test_init_contents();
        test_con_write();
        test_cpu_priority();
        test_held_req();
        test_reset_abort();
        test_init_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ramfile_ctl
`default_nettype wire

// File: doc/ramfile_ctl.md
Name: ramfile_ctl

Overview:
- Sequencer and arbiter in front of the 1Kx36 RAMFILE, which has a registered read address, one clock enable and no reset initialization in synthesis.
- After reset it walks all 1024 words and writes zeros, except SP_ADDR, which gets SP_INIT. This gives deterministic RAMFILE contents in both hardware and simulation.
- Once initialization completes, the CPU microcode port has absolute priority. A console/debug port gets access through a req/ack handshake, only on cycles the CPU leaves idle.

Parameters:
- ADDR_WIDTH, 10, RAMFILE address width; depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 36, RAMFILE word width.
- SP_ADDR, 15, word that receives SP_INIT during initialization.
- SP_INIT, 36'o777577_030303, initial stack pointer value.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- busy  out  1  high while initialization runs
- cpu_clken  in  1  CPU access strobe
- cpu_wr  in  1  CPU write
- cpu_addr  in  10  CPU address
- cpu_din  in  36  CPU write data
- con_req  in  1  console request; held high until con_ack
- con_wr  in  1  console write, sampled with con_req
- con_addr  in  10  console address, sampled with con_req
- con_din  in  36  console write data, sampled with con_req
- con_ack  out  1  console access complete; con_dout is valid
- con_dout  out  36  console read data, registered
- ram_clken  out  1  to RAMFILE clken
- ram_wr  out  1  to RAMFILE wr
- ram_addr  out  10  to RAMFILE addr
- ram_din  out  36  to RAMFILE din
- ram_dout  in  36  from RAMFILE dout; CPU reads this directly

Behaviour:
- Reset values: busy=1, con_ack=0, con_dout=0, init counter=0, init FSM=INIT, console FSM=IDLE.
- rst asserted at any time, including mid-initialization or mid-console access, aborts everything and restarts INIT from word 0. A pending console request is dropped.
- Init FSM:
  - INIT drives ram_clken=1 and ram_wr=1 with ram_addr=cnt.
  - ram_din = SP_INIT when cnt==SP_ADDR, otherwise 0.
  - cnt increments every cycle. The write at cnt==1023 is followed by a transition to RUN; the counter does not wrap.
  - INIT lasts exactly 1024 cycles. busy deasserts in the first RUN cycle.
  - During INIT, cpu_* is ignored and the console FSM stays in IDLE; con_req is not sampled.
- RAM mux in RUN:
  - cpu_clken=1: the CPU owns the RAM that cycle. ram_* = cpu_* combinationally, zero added latency.
  - Otherwise, if the console FSM is in PEND, the console owns the cycle: ram_clken=1, ram_wr=latched wr, ram_addr and ram_din from the latched values.
  - Otherwise ram_clken=0.
- Console FSM:
  - IDLE: when con_req=1 and the controller is in RUN, latch wr/addr/din and go to PEND.
  - PEND: when cpu_clken=0, issue the access and go to DATA. When cpu_clken=1, stay in PEND; the wait is unbounded.
  - DATA: ram_dout is valid for the issued address. Register it into con_dout and go to DONE.
  - DONE: con_ack=1. Stay while con_req=1; return to IDLE when con_req=0. This guarantees one access per request even if con_req is held.
- Latency: with the CPU idle, con_req rising in cycle 0 gives con_ack=1 in cycle 3.
- A console write returns the newly written word on con_dout (RAMFILE read-after-write on the same address).
- A CPU access in the console's DATA cycle is legal. It does not corrupt con_dout because capture happens at the end of that cycle, before the new read address takes effect.
- Only RUN grants console access, so no two requesters ever drive the RAM in the same cycle.

Decomposition:
- Shared package ks10_ramfile_pkg:
  - constants RAMFILE_ADDR_WIDTH, RAMFILE_DATA_WIDTH, RAMFILE_SP_ADDR, RAMFILE_SP_INIT;
  - enums for the init FSM (INIT, RUN) and the console FSM (IDLE, PEND, DATA, DONE).
- One sub-module, ramfile_ctl_con: the console handshake FSM with its latches. The init counter and the mux stay in the top module.
- The bench instantiates ramfile_ctl together with the RAMFILE.

Test Plan:
- Reset, then wait. busy is high for exactly 1024 cycles. Console reads then return 0 for address 0, 36'o777577_030303 for address 15, and 0 for address 1023.
- CPU idle; console write addr=10'o1234, data=36'o123456_701234. con_ack arrives in cycle 3 with con_dout=36'o123456_701234. A CPU read of 10'o1234 next cycle returns the same word.
- Console read with cpu_clken=1 held for 20 cycles. The console stays in PEND and ram_* follow cpu_* every cycle. con_ack comes 3 cycles after cpu_clken falls.
- con_req held high for 10 cycles past con_ack. Exactly one RAM access is issued and con_ack stays high until con_req drops. A new request after one low cycle is served.
- rst pulsed at init count 500, and again during a console PEND. busy restarts with a full 1024-cycle INIT, con_ack=0, and the pending write never reaches the RAM.
- con_req asserted during INIT. It is not accepted until RUN, then completes 3 cycles after the first RUN cycle.
